alu_arbiter: RTL and testbench

Shares the single 4-bit ALU/adder datapath (func select, operands a/b, result with cout/overflow) between two command requesters. Accepts one command at a time over a valid/ready handshake and holds operands and func stable on the ALU inputs for a fixed latency. It captures the result and flags, then returns them on a single tagged response channel. It sits between the switch/host command sources and the ALU instance and owns all ALU input sequencing.

---
 rtl/alu_arbiter_if.sv | 51 +++++
 rtl/alu_arbiter.sv | 108 ++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the two command requesters, the response consumer and
// the shared ALU. The arbiter uses the slave view; the surrounding system
// (requesters, consumer and ALU model) uses the master view.
interface alu_arbiter_if #(
  parameter int W = 4
);
  logic         req0_valid;
  logic         req0_ready;
  logic [2:0]   req0_func;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;

  logic         req1_valid;
  logic         req1_ready;
  logic [2:0]   req1_func;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;

  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_result;
  logic         rsp_cout;
  logic         rsp_overflow;
  logic         rsp_zero;

  logic [2:0]   alu_func;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         alu_overflow;

  modport slave (
    input  req0_valid, req0_func, req0_a, req0_b,
    input  req1_valid, req1_func, req1_a, req1_b,
    input  rsp_ready, alu_result, alu_cout, alu_overflow,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow, rsp_zero,
    output alu_func, alu_a, alu_b
  );

  modport master (
    output req0_valid, req0_func, req0_a, req0_b,
    output req1_valid, req1_func, req1_a, req1_b,
    output rsp_ready, alu_result, alu_cout, alu_overflow,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_cout, rsp_overflow, rsp_zero,
    input  alu_func, alu_a, alu_b
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one W-bit ALU between two requesters. One command at a
// time is accepted, held on the ALU inputs for ALU_LAT cycles, and its result
// and flags are returned on a tagged response channel.
// Build option: define ALU_ARB_RR_EN for round-robin arbitration; without it
// req0 has fixed priority over req1.
module alu_arbiter #(
  parameter int W       = 4,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Counter value on the last EXEC cycle (ALU_LAT is limited to 1..4).
  localparam logic [1:0] LAST_CNT = 2'(ALU_LAT - 1);

  state_t     state;
  logic [1:0] cnt;
  logic       last_grant;
  logic       cmd_id;
  logic       grant;
  logic       accept;

  // Pick the requester that would be served if the arbiter is idle.
  always_comb begin
    grant = 1'b0;
`ifdef ALU_ARB_RR_EN
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else                                  grant = bus.req1_valid;
`else
    grant = bus.req1_valid & ~bus.req0_valid;
`endif
  end

`ifdef ALU_ARB_RR_EN
`else
  // Fixed priority keeps last_grant tracked but never consults it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  assign bus.req0_ready = (state == IDLE) && !grant;
  assign bus.req1_ready = (state == IDLE) &&  grant;
  assign accept         = (state == IDLE) && (grant ? bus.req1_valid : bus.req0_valid);

  // Command sequencing: accept, hold operands on the ALU, capture, respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      busy             <= 1'b0;
      cnt              <= '0;
      last_grant       <= 1'b1;
      cmd_id           <= 1'b0;
      bus.alu_func     <= '0;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_cout     <= 1'b0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_zero     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // The alu_* registers double as the command register.
            bus.alu_func <= grant ? bus.req1_func : bus.req0_func;
            bus.alu_a    <= grant ? bus.req1_a    : bus.req0_a;
            bus.alu_b    <= grant ? bus.req1_b    : bus.req0_b;
            cmd_id       <= grant;
            last_grant   <= grant;
            cnt          <= '0;
            busy         <= 1'b1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == LAST_CNT) begin
            bus.rsp_result   <= bus.alu_result;
            bus.rsp_cout     <= bus.alu_cout;
            bus.rsp_overflow <= bus.alu_overflow;
            bus.rsp_zero     <= ~|bus.alu_result;
            bus.rsp_id       <= cmd_id;
            bus.rsp_valid    <= 1'b1;
            state            <= RESP;
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model of arbitration order, latency and results.
module tb_alu_arbiter;
  localparam int W   = 4;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst;
  logic busy, busy3;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.W(W)) bus ();
  alu_arbiter_if #(.W(W)) bus3 ();

  alu_arbiter #(.W(W), .ALU_LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .busy(busy));
  alu_arbiter #(.W(W), .ALU_LAT(3))   dut3 (.clk(clk), .rst(rst), .bus(bus3.slave), .busy(busy3));

  // Behavioural ALU: {overflow, cout, result}
  function automatic logic [5:0] alu_ref(input logic [2:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic [3:0] r;
    logic c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (f)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 5'd1; r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = ~(a | b);
      3'd5: r = a ^ b;
      3'd6: r = {3'b0, $signed(a) < $signed(b)};
      default: r = {3'b0, a < b};
    endcase
    return {v, c, r};
  endfunction

  assign {bus.alu_overflow, bus.alu_cout, bus.alu_result}    = alu_ref(bus.alu_func, bus.alu_a, bus.alu_b);
  assign {bus3.alu_overflow, bus3.alu_cout, bus3.alu_result} = alu_ref(bus3.alu_func, bus3.alu_a, bus3.alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Next-cycle stimulus
  logic       n_v0, n_v1, n_rr;
  logic [2:0] n_f0, n_f1;
  logic [3:0] n_a0, n_b0, n_a1, n_b1;

  // Transaction model: one outstanding command, its age in cycles, last winner
  bit         out;
  int         age;
  bit         last;
  bit         m_id;
  logic [2:0] m_f;
  logic [3:0] m_a, m_b;
  bit         took0, took1;
  bit         grants[$];

  // Snapshot of the response seen in the most recent cycle
  bit         seen;
  logic [3:0] seen_res;
  logic       seen_cout, seen_ovf, seen_zero, seen_id;

  // One clock: apply stimulus after the edge, check at the falling edge.
  task automatic tick();
    logic [5:0] e;
    bit win;
    @(posedge clk); #1;
    bus.req0_valid = n_v0; bus.req0_func = n_f0; bus.req0_a = n_a0; bus.req0_b = n_b0;
    bus.req1_valid = n_v1; bus.req1_func = n_f1; bus.req1_a = n_a1; bus.req1_b = n_b1;
    bus.rsp_ready  = n_rr;
    @(negedge clk);
    took0 = 0; took1 = 0; seen = 0;
    if (out) begin
      age++;
      check("busy_active", busy, 1);
      check("rdy0_active", bus.req0_ready, 0);
      check("rdy1_active", bus.req1_ready, 0);
      check("rsp_valid_timing", bus.rsp_valid, age > LAT);
      if (age <= LAT) begin
        check("alu_func", bus.alu_func, m_f);
        check("alu_a", bus.alu_a, m_a);
        check("alu_b", bus.alu_b, m_b);
      end else begin
        e = alu_ref(m_f, m_a, m_b);
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_result", bus.rsp_result, e[3:0]);
        check("rsp_cout", bus.rsp_cout, e[4]);
        check("rsp_overflow", bus.rsp_overflow, e[5]);
        check("rsp_zero", bus.rsp_zero, e[3:0] == 4'd0);
        seen = 1; seen_res = bus.rsp_result; seen_cout = bus.rsp_cout;
        seen_ovf = bus.rsp_overflow; seen_zero = bus.rsp_zero; seen_id = bus.rsp_id;
        if (bus.rsp_ready) out = 0;
      end
    end else begin
      check("busy_idle", busy, 0);
      check("rsp_valid_idle", bus.rsp_valid, 0);
      if (bus.req0_valid || bus.req1_valid) begin
`ifdef ALU_ARB_RR_EN
        win = (bus.req0_valid && bus.req1_valid) ? !last : bus.req1_valid;
`else
        win = !bus.req0_valid;
`endif
        check("rdy0_idle", bus.req0_ready, !win);
        check("rdy1_idle", bus.req1_ready, win);
        out = 1; age = 0; last = win; m_id = win;
        m_f = win ? bus.req1_func : bus.req0_func;
        m_a = win ? bus.req1_a    : bus.req0_a;
        m_b = win ? bus.req1_b    : bus.req0_b;
        took0 = !win; took1 = win;
        grants.push_back(win);
      end
    end
  endtask

  task automatic run_until_rsp(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!seen && n < 20);
    if (!seen) check("rsp_timeout", 0, 1);
  endtask

  task automatic plan_random(input int pv);
    if (took0 || !n_v0) begin
      n_v0 = ($urandom_range(0, 99) < pv);
      n_f0 = 3'($urandom_range(0, 7)); n_a0 = 4'($urandom_range(0, 15)); n_b0 = 4'($urandom_range(0, 15));
    end
    if (took1 || !n_v1) begin
      n_v1 = ($urandom_range(0, 99) < pv);
      n_f1 = 3'($urandom_range(0, 7)); n_a1 = 4'($urandom_range(0, 15)); n_b1 = 4'($urandom_range(0, 15));
    end
    n_rr = ($urandom_range(0, 3) != 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, c0, c1;
    bit exp_g;
    rst = 1'b0;
    n_v0 = 0; n_f0 = 0; n_a0 = 0; n_b0 = 0;
    n_v1 = 0; n_f1 = 0; n_a1 = 0; n_b1 = 0; n_rr = 1;
    bus.req0_valid = 0; bus.req0_func = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_func = 0; bus.req1_a = 0; bus.req1_b = 0; bus.rsp_ready = 1;
    bus3.req0_valid = 0; bus3.req0_func = 0; bus3.req0_a = 0; bus3.req0_b = 0;
    bus3.req1_valid = 0; bus3.req1_func = 0; bus3.req1_a = 0; bus3.req1_b = 0; bus3.rsp_ready = 1;
    out = 0; age = 0; last = 1; took0 = 0; took1 = 0; seen = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_alu_func", bus.alu_func, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_rsp_result", bus.rsp_result, 0);
    check("rst_rsp_zero", bus.rsp_zero, 0);
    #2 rst = 1'b1;

    // ALU_LAT=3 instance: xor 9^4 held for three EXEC cycles
    @(posedge clk); #1;
    bus3.req0_valid = 1; bus3.req0_func = 3'd5; bus3.req0_a = 4'd9; bus3.req0_b = 4'd4;
    @(negedge clk);
    check("l3_accept", bus3.req0_ready, 1);
    @(posedge clk); #1;
    bus3.req0_valid = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("l3_exec_rsp_valid", bus3.rsp_valid, 0);
      check("l3_busy", busy3, 1);
      check("l3_alu_func", bus3.alu_func, 5);
      check("l3_alu_a", bus3.alu_a, 9);
      check("l3_alu_b", bus3.alu_b, 4);
    end
    @(negedge clk);
    check("l3_rsp_valid", bus3.rsp_valid, 1);
    check("l3_rsp_result", bus3.rsp_result, 13);
    check("l3_rsp_id", bus3.rsp_id, 0);

    // Single add 3+5
    n_v0 = 1; n_f0 = 3'd0; n_a0 = 4'd3; n_b0 = 4'd5; n_rr = 1;
    tick();
    check("add_accept", took0, 1);
    n_v0 = 0;
    run_until_rsp(n);
    check("add_latency", n, LAT + 1);
    check("add_result", seen_res, 8);
    check("add_cout", seen_cout, 0);
    check("add_overflow", seen_ovf, 1);
    check("add_zero", seen_zero, 0);
    check("add_id", seen_id, 0);

    // Subtract to zero from requester 1
    n_v1 = 1; n_f1 = 3'd1; n_a1 = 4'd7; n_b1 = 4'd7;
    tick();
    check("sub_accept", took1, 1);
    n_v1 = 0;
    run_until_rsp(n);
    check("sub_result", seen_res, 0);
    check("sub_zero", seen_zero, 1);
    check("sub_id", seen_id, 1);

    // Both requesters busy with four commands each
    grants.delete();
    c0 = 4; c1 = 4; n_v0 = 1; n_v1 = 1; n_rr = 1;
    for (int i = 0; i < 200 && grants.size() < 8; i++) begin
      tick();
      if (took0) begin c0--; n_v0 = (c0 > 0); n_a0 = 4'($urandom_range(0, 15)); n_f0 = 3'($urandom_range(0, 7)); end
      if (took1) begin c1--; n_v1 = (c1 > 0); n_b1 = 4'($urandom_range(0, 15)); n_f1 = 3'($urandom_range(0, 7)); end
    end
    check("grant_count", grants.size(), 8);
    for (int i = 0; i < grants.size() && i < 8; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = (i % 2) == 1;
`else
      exp_g = (i >= 4);
`endif
      check("grant_order", grants[i], exp_g);
    end
    n_v0 = 0; n_v1 = 0;
    for (int i = 0; i < 20 && out; i++) tick();

    // Response backpressure with requester 1 waiting
    n_v0 = 1; n_f0 = 3'd3; n_a0 = 4'd10; n_b0 = 4'd5;
    n_v1 = 1; n_f1 = 3'd2; n_a1 = 4'd12; n_b1 = 4'd6; n_rr = 0;
    tick();
    check("bp_accept", took0, 1);
    n_v0 = 0;
    run_until_rsp(n);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rsp_held", seen, 1);
      check("bp_held_result", seen_res, 15);
    end
    n_rr = 1;
    tick();
    tick();
    check("bp_next_accept", took1, 1);
    n_v1 = 0;
    run_until_rsp(n);
    check("bp_req1_result", seen_res, 4);

    // Reset during EXEC discards the command
    n_v0 = 1; n_f0 = 3'd0; n_a0 = 4'd1; n_b0 = 4'd2;
    tick();
    check("rstx_accept", took0, 1);
    n_v0 = 0;
    @(posedge clk); #2;
    bus.req0_valid = 0;
    rst = 1'b0;
    #1;
    check("rstx_rsp_valid", bus.rsp_valid, 0);
    check("rstx_busy", busy, 0);
    check("rstx_alu_a", bus.alu_a, 0);
    check("rstx_alu_b", bus.alu_b, 0);
    check("rstx_alu_func", bus.alu_func, 0);
    check("rstx_rsp_result", bus.rsp_result, 0);
    out = 0; age = 0; last = 1; took0 = 0; took1 = 0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) tick();
    n_v0 = 1; n_f0 = 3'd0; n_a0 = 4'd4; n_b0 = 4'd4;
    tick();
    check("rstx_new_accept", took0, 1);
    n_v0 = 0;
    run_until_rsp(n);
    check("rstx_new_result", seen_res, 8);
    check("rstx_new_id", seen_id, 0);

    // Randomized traffic
    took0 = 0; took1 = 0;
    for (int i = 0; i < 400; i++) begin
      plan_random(70);
      tick();
    end
    n_v0 = 0; n_v1 = 0; n_rr = 1;
    for (int i = 0; i < 20 && out; i++) tick();
    check("drain_idle", out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
